// File: rtl/mvm_scheduler_pkg.sv
// Shared types and constants for the MVM engine scheduler.
// Optional watchdog in mvm_scheduler is enabled by defining MVM_SCHED_TIMEOUT_EN.
package mvm_sched_pkg;

    localparam int QN_DEF = 6;
    localparam int QM_DEF = 11;

    function automatic int LAYER_BITWIDTH(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    localparam int BITWIDTH = LAYER_BITWIDTH(QN_DEF, QM_DEF);

    // A single requester still gets a one-bit index so no port collapses to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE    = 2'd0;
    localparam sched_state_t ST_START   = 2'd1;
    localparam sched_state_t ST_WAIT    = 2'd2;
    localparam sched_state_t ST_DELIVER = 2'd3;

endpackage

// File: rtl/mvm_scheduler_if.sv
// Requester/engine bus of the MVM scheduler; the scheduler sits on the slave modport.
interface mvm_scheduler_if #(
    parameter int N_REQ    = 4,
    parameter int NROW     = 16,
    parameter int BITWIDTH = mvm_sched_pkg::BITWIDTH
) ();
    import mvm_sched_pkg::*;

    localparam int IDW = idx_width(N_REQ);

    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         grant;
    logic [N_REQ-1:0]         done;
    logic                     engine_start;
    logic                     engine_done;
    logic [BITWIDTH*NROW-1:0] engine_result;
    logic [BITWIDTH*NROW-1:0] result_vec;
    logic [IDW-1:0]           result_id;
    logic                     result_valid;
    logic                     err;

    modport slave (
        input  req,
        input  engine_done,
        input  engine_result,
        output grant,
        output done,
        output engine_start,
        output result_vec,
        output result_id,
        output result_valid,
        output err
    );

    modport master (
        output req,
        output engine_done,
        output engine_result,
        input  grant,
        input  done,
        input  engine_start,
        input  result_vec,
        input  result_id,
        input  result_valid,
        input  err
    );

endinterface

// File: rtl/mvm_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set request after last_idx, wrapping.
module rr_arbiter
    import mvm_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_idx,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_idx,
    output logic             any
);

    // Two passes instead of a modulo: indices above last_idx first, then the wrapped part.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i] && (i > int'(last_idx))) begin
                any     = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = i[IDW-1:0];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i] && (i <= int'(last_idx))) begin
                any     = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = i[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/mvm_scheduler.sv
// Time-shares one MVM engine among N_REQ requesters in round-robin order.
// Define MVM_SCHED_TIMEOUT_EN to build the WAIT-state watchdog (TIMEOUT_CYC cycles).
//
//   state   | meaning
//   IDLE    | no owner; pick round-robin winner when any req is set
//   START   | one-cycle engine_start pulse to the engine
//   WAIT    | owner holds the engine until engine_done (or watchdog)
//   DELIVER | one-cycle done / result_valid (or err) to the owner
module mvm_scheduler
    import mvm_sched_pkg::*;
#(
    parameter int NROW        = 16,
    parameter int QN          = 6,
    parameter int QM          = 11,
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic           clk,
    input logic           reset,
    mvm_scheduler_if.slave bus
);

    localparam int BW  = LAYER_BITWIDTH(QN, QM);
    localparam int VW  = BW * NROW;
    localparam int IDW = idx_width(N_REQ);

    sched_state_t     state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   result_id_q, result_id_d;
    logic [VW-1:0]    result_vec_q, result_vec_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDW-1:0]   arb_idx;
    logic             arb_any;
    logic [N_REQ-1:0] done_oh;

`ifdef MVM_SCHED_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
    logic           abort_q, abort_d;
    logic           wd_hit;

    assign wd_hit = (wd_cnt_q == WDW'(TIMEOUT_CYC - 1));
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_arbiter (
        .req      (bus.req),
        .last_idx (last_q),
        .gnt      (arb_gnt),
        .gnt_idx  (arb_idx),
        .any      (arb_any)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        id_d         = id_q;
        last_d       = last_q;
        result_id_d  = result_id_q;
        result_vec_d = result_vec_q;
`ifdef MVM_SCHED_TIMEOUT_EN
        wd_cnt_d     = wd_cnt_q;
        abort_d      = abort_q;
`endif
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (arb_any) begin
                    grant_d = arb_gnt;
                    id_d    = arb_idx;
                    last_d  = arb_idx;
                    state_d = ST_START;
                end
            end
            ST_START: begin
`ifdef MVM_SCHED_TIMEOUT_EN
                wd_cnt_d = '0;
                abort_d  = 1'b0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // req is deliberately ignored here: a dropped request still gets its done.
                if (bus.engine_done) begin
                    result_vec_d = bus.engine_result;
                    result_id_d  = id_q;
                    grant_d      = '0;
                    state_d      = ST_DELIVER;
                end
`ifdef MVM_SCHED_TIMEOUT_EN
                else if (wd_hit) begin
                    abort_d = 1'b1;
                    grant_d = '0;
                    state_d = ST_DELIVER;
                end else begin
                    wd_cnt_d = wd_cnt_q + WDW'(1);
                end
`endif
            end
            ST_DELIVER: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            id_q         <= '0;
            last_q       <= IDW'(N_REQ - 1);
            result_id_q  <= '0;
            result_vec_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            id_q         <= id_d;
            last_q       <= last_d;
            result_id_q  <= result_id_d;
            result_vec_q <= result_vec_d;
        end
    end

`ifdef MVM_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_q <= '0;
            abort_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            abort_q  <= abort_d;
        end
    end
`endif

    always_comb begin
        done_oh = '0;
        if (state_q == ST_DELIVER) begin
            done_oh[id_q] = 1'b1;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.done         = done_oh;
    assign bus.engine_start = (state_q == ST_START);
    assign bus.result_vec   = result_vec_q;
    assign bus.result_id    = result_id_q;

`ifdef MVM_SCHED_TIMEOUT_EN
    assign bus.result_valid = (state_q == ST_DELIVER) && !abort_q;
    assign bus.err          = (state_q == ST_DELIVER) && abort_q;
`else
    assign bus.result_valid = (state_q == ST_DELIVER);
    assign bus.err          = 1'b0;
`endif

endmodule

// File: tb/tb_mvm_scheduler.sv
// Randomized bench for mvm_scheduler against a round-robin reference model.
module tb_mvm_scheduler;

    localparam int NR   = 4;
    localparam int NROW = 16;
    localparam int BWD  = 18;
    localparam int VW   = NROW * BWD;
    localparam int IDW  = 2;
    localparam int TO   = 8;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_err    = 0;

    int             last_srv;
    bit             after_deliver;
    logic [VW-1:0]  exp_vec;
    logic [IDW-1:0] exp_rid;
    logic [NR-1:0]  g;
    logic [NR-1:0]  rr_seq [5];

    mvm_scheduler_if #(.N_REQ(NR), .NROW(NROW), .BITWIDTH(BWD)) bus ();

    mvm_scheduler #(
        .NROW        (NROW),
        .QN          (6),
        .QM          (11),
        .N_REQ       (NR),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] r, input int last);
        logic [NR-1:0] t;
        int c;
        for (int k = 1; k <= NR; k++) begin
            c = (last + k) % NR;
            t = r >> c;
            if (t[0]) return c;
        end
        return 0;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, bus.grant, '0);
        chk({tag, "_done"}, bus.done, '0);
        chk({tag, "_start"}, bus.engine_start, '0);
        chk({tag, "_rvalid"}, bus.result_valid, '0);
        chk({tag, "_err"}, bus.err, '0);
        chk({tag, "_rid"}, bus.result_id, '0);
        chk({tag, "_rvec"}, bus.result_vec, '0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.req = '0;
        bus.engine_done = 1'b0;
        @(negedge clk);
        chk_all_zero("rst1");
        @(negedge clk);
        chk_all_zero("rst2");
        reset = 1'b1;
        last_srv = NR - 1;
        after_deliver = 1'b0;
        exp_vec = '0;
        exp_rid = '0;
    endtask

    // Called on a negedge where the scheduler is in IDLE or DELIVER; returns on the DELIVER negedge.
    task automatic do_op(input logic [NR-1:0] r, input int lat, input int gap, input bit drop,
                         input bit early, input logic [VW-1:0] res, output logic [NR-1:0] g_obs);
        int w;
        int nw;
        logic [NR-1:0] oh;
        w  = rr_pick(r, last_srv);
        oh = NR'(1) << w;
        if (gap > 0) begin
            bus.req = '0;
            repeat (gap) @(negedge clk);
            after_deliver = 1'b0;
        end
        nw = after_deliver ? 2 : 1;
        bus.req = r;
        for (int k = 1; k < nw; k++) begin
            @(negedge clk);
            chk("idle_start", bus.engine_start, 1'b0);
            chk("idle_done", bus.done, '0);
        end
        @(negedge clk);
        chk("start", bus.engine_start, 1'b1);
        chk("grant", bus.grant, oh);
        g_obs = bus.grant;
        if (early) begin
            bus.engine_done = 1'b1;
            bus.engine_result = ~res;
        end
        for (int j = 1; j < lat; j++) begin
            @(negedge clk);
            bus.engine_done = 1'b0;
            if (drop && j == 1) bus.req = r & ~oh;
            chk("wait_start", bus.engine_start, 1'b0);
            chk("wait_done", bus.done, '0);
            chk("wait_grant", bus.grant, oh);
        end
        @(negedge clk);
        bus.engine_done = 1'b1;
        bus.engine_result = res;
        @(negedge clk);
        bus.engine_done = 1'b0;
        exp_vec = res;
        exp_rid = IDW'(w);
        chk("dlv_done", bus.done, oh);
        chk("dlv_rvalid", bus.result_valid, 1'b1);
        chk("dlv_err", bus.err, 1'b0);
        chk("dlv_rid", bus.result_id, exp_rid);
        chk("dlv_rvec", bus.result_vec, exp_vec);
        chk("dlv_grant", bus.grant, '0);
        last_srv = w;
        after_deliver = 1'b1;
        bus.req = '0;
    endtask

`ifdef MVM_SCHED_TIMEOUT_EN
    task automatic do_timeout(input logic [NR-1:0] r);
        int w;
        logic [NR-1:0] oh;
        w  = rr_pick(r, last_srv);
        oh = NR'(1) << w;
        bus.req = r;
        if (after_deliver) begin
            @(negedge clk);
            chk("to_idle_start", bus.engine_start, 1'b0);
        end
        @(negedge clk);
        chk("to_start", bus.engine_start, 1'b1);
        chk("to_grant", bus.grant, oh);
        for (int j = 1; j <= TO; j++) begin
            @(negedge clk);
            chk("to_wait_done", bus.done, '0);
            chk("to_wait_err", bus.err, 1'b0);
        end
        @(negedge clk);
        chk("to_err", bus.err, 1'b1);
        chk("to_done", bus.done, oh);
        chk("to_rvalid", bus.result_valid, 1'b0);
        chk("to_rvec", bus.result_vec, exp_vec);
        chk("to_rid", bus.result_id, exp_rid);
        last_srv = w;
        after_deliver = 1'b1;
        bus.req = '0;
    endtask
`endif

    initial begin
        bus.req = '0;
        bus.engine_done = 1'b0;
        bus.engine_result = '0;
        reset = 1'b0;
        last_srv = NR - 1;
        after_deliver = 1'b0;
        exp_vec = '0;
        exp_rid = '0;
        rr_seq[0] = 4'b0001;
        rr_seq[1] = 4'b0010;
        rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000;
        rr_seq[4] = 4'b0001;
        @(negedge clk);
        do_reset();

        // single requester, engine_done three cycles after engine_start
        do_op(4'b0100, 3, 0, 1'b0, 1'b0, VW'(18'h1234), g);
        chk("single_grant", g, 4'b0100);
        chk("single_rid", bus.result_id, 2'd2);
        chk("single_lane0", bus.result_vec[17:0], 18'h1234);

        // all requesters held after reset
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_op(4'b1111, $urandom_range(1, 5), 0, 1'b0, 1'b0, rand_vec(), g);
            chk("rr_seq", g, rr_seq[i]);
        end

        // priority shift: after serving 1, index 0 wins over 1
        do_op(4'b0010, 2, 0, 1'b0, 1'b0, rand_vec(), g);
        do_op(4'b0011, 2, 0, 1'b0, 1'b0, rand_vec(), g);
        chk("fair_after_1", g, 4'b0001);

        // request dropped in WAIT still completes
        do_op(4'b1000, 4, 0, 1'b1, 1'b0, rand_vec(), g);
        chk("drop_grant", g, 4'b1000);

        // engine_done during START is ignored
        do_op(4'b0001, 3, 0, 1'b0, 1'b1, rand_vec(), g);

        for (int i = 0; i < 40; i++) begin
            logic [NR-1:0] r;
            int lat;
            r   = NR'($urandom_range(1, 15));
            lat = $urandom_range(1, 6);
            do_op(r, lat, $urandom_range(0, 2), (lat >= 2) && ($urandom_range(0, 3) == 0),
                  (lat >= 2) && ($urandom_range(0, 4) == 0), rand_vec(), g);
        end

`ifdef MVM_SCHED_TIMEOUT_EN
        do_timeout(4'b0110);
        do_op(4'b1111, 2, 0, 1'b0, 1'b0, rand_vec(), g);
`else
        do_op(4'b0110, 20, 0, 1'b0, 1'b0, rand_vec(), g);
`endif

        // reset while the engine is busy drops the operation
        bus.req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        chk("rw_start", bus.engine_start, 1'b1);
        @(negedge clk);
        do_reset();
        repeat (3) begin
            @(negedge clk);
            chk("rw_no_done", bus.done, '0);
            chk("rw_no_rvalid", bus.result_valid, 1'b0);
        end
        do_op(4'b0101, 2, 0, 1'b0, 1'b0, rand_vec(), g);
        chk("rw_next_grant", g, 4'b0001);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mvm_scheduler.md
MVM_SCHEDULER -- requirements
Module: mvm_scheduler

Interface
REQ-001 Parameter NROW, default 16, output rows of the shared matrix-vector (MVM) engine.
REQ-002 Parameter QN, default 6, integer bits; QM, default 11, fraction bits; BITWIDTH = QN+QM+1.
REQ-003 Parameter N_REQ, default 4, number of requesters (LSTM gates i, f, o, c~).
REQ-004 Parameter TIMEOUT_CYC, default 1024, watchdog limit in clk cycles.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low; 0 = in reset.
REQ-007 req  in  N_REQ  per-requester level request, held until its done pulse.
REQ-008 grant  out  N_REQ  one-hot owner of the engine; drives the weight-bank select.
REQ-009 done  out  N_REQ  one-cycle pulse to the served requester.
REQ-010 engine_start  out  1  one-cycle start pulse to the MVM engine.
REQ-011 engine_done  in  1  engine result-valid pulse.
REQ-012 engine_result  in  BITWIDTH*NROW  engine output vector.
REQ-013 result_vec  out  BITWIDTH*NROW  captured result, held until the next capture.
REQ-014 result_id  out  log2(N_REQ)  binary index of the requester owning result_vec.
REQ-015 result_valid  out  1  one-cycle pulse, coincident with done.
REQ-016 err  out  1  one-cycle pulse on watchdog abort.

Function
REQ-017 FSM states: IDLE, START, WAIT, DELIVER; no other reachable state; illegal encodings go to IDLE.
REQ-018 IDLE: if any req bit is set, register the round-robin winner into grant and go to START; otherwise stay and hold grant = 0.
REQ-019 Round-robin: search begins at last served index + 1 and wraps modulo N_REQ; the winner becomes the new last served index.
REQ-020 START: engine_start = 1 for exactly one cycle, then go to WAIT; engine_done is ignored in START.
REQ-021 WAIT: on engine_done, capture engine_result into result_vec and the grant index into result_id, then go to DELIVER.
REQ-022 DELIVER: done[id] = 1 and result_valid = 1 for one cycle; grant clears; go to IDLE.
REQ-023 Latency: req sampled in IDLE at edge N; engine_start is high in cycle N+1; done is high one cycle after the engine_done cycle.
REQ-024 Minimum spacing between consecutive engine_start pulses is 4 cycles: IDLE, START, WAIT (at least one cycle), DELIVER.
REQ-025 A req deasserted after grant does not abort the operation; the result and done are still delivered to that index.
REQ-026 Simultaneous requests are served one at a time in round-robin order; there is no starvation, and the wait is bounded by N_REQ operations.
REQ-027 The scheduler performs no arithmetic; result_vec is a bit-exact copy of engine_result.

Reset
REQ-028 While reset = 0, all outputs are 0, the FSM is in IDLE, and the last served index is N_REQ-1, so req[0] has first priority.
REQ-029 Reset asserted mid-operation drops the operation silently: no done pulse and no result_valid pulse.

Configuration
REQ-030 Macro MVM_SCHED_TIMEOUT_EN, when defined, enables the watchdog.
REQ-031 Watchdog: a counter is cleared on entry to WAIT and increments each WAIT cycle. On reaching TIMEOUT_CYC without engine_done, go to DELIVER with err = 1; done[id] still pulses; result_vec is unchanged; result_valid = 0.
REQ-032 Without the macro, err is tied to 0, no counter is built, and WAIT lasts indefinitely.

Structure
REQ-033 Package mvm_sched_pkg holds the state enum, BITWIDTH, and the LAYER_BITWIDTH helper function and constants.
REQ-034 Sub-module rr_arbiter (request vector and last index in; one-hot grant and index out; purely combinational) holds the round-robin search.

Verification
REQ-035 Single requester: req = 4'b0100 and engine_done three cycles after engine_start with result 0x1234 in lane 0 -> result_id = 2, done = 4'b0100, result_vec lane 0 = 0x1234.
REQ-036 All requesters: req = 4'b1111 held after reset -> grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-037 Fairness after priority shift: serve index 1, then req = 4'b0011 -> index 0 is granted next.
REQ-038 Request drop: req[3] drops in WAIT -> done[3] still pulses once.
REQ-039 Reset in WAIT: reset low for 2 cycles -> all outputs 0, no done pulse; next grant goes to req[0].
REQ-040 With MVM_SCHED_TIMEOUT_EN and TIMEOUT_CYC = 8, engine_done is never returned -> err and done pulse together 8 WAIT cycles after engine_start; result_valid = 0.
